mem_ctrl_arb: RTL

- Parametrised successor of the two-port (IF/MEM) memory controller.
- Serialises 1..MAX_LEN-byte read/write requests from NUM_CH requesters onto the 8-bit external RAM bus.
- Arbitration is fixed-priority or round-robin; in-flight reads are cancellable per channel; the block freezes while rdy_in is low.
- Sits between pipeline stages (IF, MEM, future I-cache/D-cache) and cpu's mem_din/mem_dout/mem_a/mem_wr.

---
 rtl/mem_ctrl_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_arb.sv
// Multi-channel memory controller: arbitrates NUM_CH byte-stream requesters onto
// an 8-bit RAM bus with one-cycle read latency, cancellable reads and a global pause.
module mem_ctrl_arb #(
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = 0,
  parameter int MAX_LEN   = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic [NUM_CH-1:0]             req_in,
  input  logic [NUM_CH-1:0]             rw_in,
  input  logic [32*NUM_CH-1:0]          addr_in,
  input  logic [8*MAX_LEN*NUM_CH-1:0]   wdata_in,
  input  logic [3*NUM_CH-1:0]           len_in,
  input  logic [NUM_CH-1:0]             cancel_in,
  output logic [NUM_CH-1:0]             busy_out,
  output logic [NUM_CH-1:0]             done_out,
  output logic [8*MAX_LEN-1:0]          rdata_out,
  input  logic [7:0]                    ram_din,
  output logic [7:0]                    ram_dout,
  output logic [31:0]                   ram_a,
  output logic                          ram_wr
);
  localparam int          CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          DW   = 8*MAX_LEN;
  localparam logic [2:0]  LMAX = 3'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RD, RD_TAIL, WR} state_e;

  state_e              state_q;
  logic [CW-1:0]       own_q, ptr_q, win;
  logic                found;
  logic [NUM_CH-1:0]   busy_q, done_q, elig, win_oh;
  logic [2:0]          idx_q, last_q, lraw, lnorm, samp_idx;
  logic [DW-1:0]       wbuf_q, res_q, res_n, rdata_q;
  logic [7:0]          dout_q;
  logic [31:0]         a_q;
  logic                wr_q;

  // A channel whose done pulse is showing still holds req this cycle; masking it
  // keeps the same transaction from being accepted twice.
  assign elig = req_in & ~cancel_in & ~done_q;

  always_comb begin
    int c;
    c     = 0;
    win   = '0;
    found = 1'b0;
    if (PRIO_MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++)
        if (elig[i]) begin
          win   = CW'(i);
          found = 1'b1;
        end
    end else begin
      // Walk offsets from farthest to nearest so the nearest eligible after ptr wins.
      for (int i = NUM_CH; i >= 1; i--) begin
        c = (int'(ptr_q) + i) % NUM_CH;
        if (elig[c]) begin
          win   = CW'(c);
          found = 1'b1;
        end
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_comb begin
    lraw  = len_in[3*win +: 3];
    lnorm = (lraw == 3'd0) ? 3'd1 : ((lraw > LMAX) ? LMAX : lraw);
  end

  // Byte arriving on ram_din belongs to the address driven one cycle earlier.
  always_comb begin
    samp_idx = (state_q == RD_TAIL) ? idx_q : idx_q - 3'd1;
    res_n    = res_q;
    if ((state_q == RD && idx_q != 3'd0) || state_q == RD_TAIL)
      res_n[{samp_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= CW'(NUM_CH-1);
      busy_q  <= '0;
      done_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      wbuf_q  <= '0;
      res_q   <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      a_q     <= '0;
      wr_q    <= 1'b0;
    end else if (rdy_in) begin
      done_q <= '0;
      case (state_q)
        IDLE: if (found) begin
          own_q  <= win;
          if (PRIO_MODE != 0) ptr_q <= win;
          busy_q <= win_oh;
          a_q    <= addr_in[32*win +: 32];
          idx_q  <= '0;
          last_q <= lnorm - 3'd1;
          res_q  <= '0;
          if (rw_in[win]) begin
            state_q <= WR;
            wr_q    <= 1'b1;
            dout_q  <= wdata_in[DW*win +: 8];
            wbuf_q  <= wdata_in[DW*win +: DW] >> 8;
          end else begin
            state_q <= RD;
          end
        end
        WR: begin
          if (idx_q == last_q) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            busy_q  <= '0;
            done_q  <= busy_q;
          end else begin
            idx_q  <= idx_q + 3'd1;
            a_q    <= a_q + 32'd1;
            dout_q <= wbuf_q[7:0];
            wbuf_q <= wbuf_q >> 8;
          end
        end
        default: begin
          if (cancel_in[own_q]) begin
            state_q <= IDLE;
            busy_q  <= '0;
          end else begin
            res_q <= res_n;
            if (state_q == RD_TAIL) begin
              state_q <= IDLE;
              busy_q  <= '0;
              done_q  <= busy_q;
              rdata_q <= res_n;
            end else if (idx_q == last_q) begin
              state_q <= RD_TAIL;
            end else begin
              idx_q <= idx_q + 3'd1;
              a_q   <= a_q + 32'd1;
            end
          end
        end
      endcase
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign rdata_out = rdata_q;
  assign ram_dout  = dout_q;
  assign ram_a     = a_q;
  assign ram_wr    = wr_q & rdy_in;
endmodule
